// File: rtl/imem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : imem_port_arbiter
// Brief    : Fetch/data arbiter for one shared fixed-latency memory port.
//            Data has priority, with a starvation guard for fetch.
// Revision : 1.0
// ============================================================================
module imem_port_arbiter #(
   parameter int unsigned MEM_LAT    = 2,
   parameter int unsigned STARVE_MAX = 4
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        f_req_i,
   input  logic [63:0] f_addr_i,
   input  logic        f_flush_i,
   output logic        f_gnt_o,
   output logic        f_valid_o,
   output logic [31:0] f_rdata_o,
   input  logic        d_req_i,
   input  logic        d_we_i,
   input  logic [63:0] d_addr_i,
   input  logic [63:0] d_wdata_i,
   output logic        d_gnt_o,
   output logic        d_valid_o,
   output logic [63:0] d_rdata_o,
   output logic        mem_en_o,
   output logic        mem_we_o,
   output logic [63:0] mem_addr_o,
   output logic [63:0] mem_wdata_o,
   input  logic [63:0] mem_rdata_i
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      F_BUSY = 2'd1,
      D_BUSY = 2'd2
   } state_e;

   localparam logic [2:0] LAT_INIT   = 3'(MEM_LAT - 1);
   localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

   state_e     state_q, state_d;
   logic [2:0] lat_q, lat_d;
   logic [3:0] starve_q, starve_d;
   logic       kill_q, kill_d;
   logic       hi_q, hi_d;
   logic       load_q, load_d;

   logic       idle;
   logic       fetch_win;
   logic       data_win;
   logic       f_done;
   logic       d_done;

   // Grants are combinational; gating with rst_ni keeps them low during reset.
   always_comb begin
      idle      = rst_ni && (state_q == IDLE);
      fetch_win = idle && f_req_i && (!d_req_i || (starve_q == STARVE_LIM));
      data_win  = idle && d_req_i && !fetch_win;
      f_done    = (state_q == F_BUSY) && (lat_q == 3'd0);
      d_done    = (state_q == D_BUSY) && (lat_q == 3'd0);
   end

   always_comb begin
      state_d  = state_q;
      lat_d    = lat_q;
      starve_d = starve_q;
      kill_d   = kill_q;
      hi_d     = hi_q;
      load_d   = load_q;

      case (state_q)
         IDLE: begin
            if (fetch_win) begin
               state_d = F_BUSY;
               lat_d   = LAT_INIT;
               hi_d    = f_addr_i[2];
               kill_d  = f_flush_i;
            end else if (data_win) begin
               state_d = D_BUSY;
               lat_d   = LAT_INIT;
               load_d  = !d_we_i;
            end
         end
         F_BUSY: begin
            if (f_flush_i) kill_d = 1'b1;
            if (lat_q == 3'd0) begin
               state_d = IDLE;
               kill_d  = 1'b0;
            end else begin
               lat_d = lat_q - 3'd1;
            end
         end
         D_BUSY: begin
            if (lat_q == 3'd0) state_d = IDLE;
            else               lat_d   = lat_q - 3'd1;
         end
         default: state_d = IDLE;
      endcase

      if (!f_req_i || fetch_win)
         starve_d = 4'd0;
      else if (data_win && (starve_q != STARVE_LIM))
         starve_d = starve_q + 4'd1;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= IDLE;
         lat_q    <= 3'd0;
         starve_q <= 4'd0;
         kill_q   <= 1'b0;
         hi_q     <= 1'b0;
         load_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         lat_q    <= lat_d;
         starve_q <= starve_d;
         kill_q   <= kill_d;
         hi_q     <= hi_d;
         load_q   <= load_d;
      end
   end

   // A flush arriving in the completion cycle itself also suppresses the result.
   always_comb begin
      f_gnt_o     = fetch_win;
      d_gnt_o     = data_win;
      mem_en_o    = fetch_win || data_win;
      mem_we_o    = data_win && d_we_i;
      mem_addr_o  = fetch_win ? f_addr_i : (data_win ? d_addr_i : 64'd0);
      mem_wdata_o = data_win ? d_wdata_i : 64'd0;
      f_valid_o   = f_done && !kill_q && !f_flush_i;
      f_rdata_o   = f_valid_o ? (hi_q ? mem_rdata_i[63:32] : mem_rdata_i[31:0]) : 32'd0;
      d_valid_o   = d_done;
      d_rdata_o   = (d_done && load_q) ? mem_rdata_i : 64'd0;
   end

endmodule
`default_nettype wire

// File: doc/imem_port_arbiter.md
IMEM_PORT_ARBITER -- requirements
Module: imem_port_arbiter

Interface
REQ-001 SHALL have parameter MEM_LAT, default 2, memory read latency in cycles (legal 1..7).
REQ-002 SHALL have parameter STARVE_MAX, default 4, consecutive data grants tolerated while fetch waits (legal 1..15).
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  asynchronous, active-low reset; 0 clears all state immediately.
REQ-005 f_req  input  1  fetch-stage access request.
REQ-006 f_addr  input  64  fetch address (PC).
REQ-007 f_flush  input  1  branch-taken kill for the outstanding fetch.
REQ-008 f_gnt  output  1  fetch granted this cycle.
REQ-009 f_valid  output  1  fetch data valid (one-cycle pulse).
REQ-010 f_rdata  output  32  instruction word.
REQ-011 d_req, d_we  input  1 each  data-port request; write enable.
REQ-012 d_addr, d_wdata  input  64 each  data address; write data.
REQ-013 d_gnt, d_valid  output  1 each  data grant; completion pulse.
REQ-014 d_rdata  output  64  load data.
REQ-015 mem_en, mem_we  output  1 each  memory access strobe; write enable.
REQ-016 mem_addr, mem_wdata  output  64 each  memory address; write data.
REQ-017 mem_rdata  input  64  memory read data, valid MEM_LAT cycles after mem_en.

Function
REQ-018 SHALL implement FSM states IDLE, F_BUSY, D_BUSY; grants issue only in IDLE.
REQ-019 In IDLE with any request: SHALL assert exactly one gnt, mem_en=1 for that cycle only, mem_addr/mem_we/mem_wdata driven combinationally from the winner, and enter F_BUSY or D_BUSY next edge.
REQ-020 Priority: data wins when both request, unless starve_cnt==STARVE_MAX, in which case fetch wins.
REQ-021 starve_cnt (4-bit) SHALL increment on each data grant while f_req=1, saturate at STARVE_MAX, clear on fetch grant or any cycle with f_req=0.
REQ-022 Grant cycle = T; latency counter loads MEM_LAT-1 and decrements each BUSY cycle; at T+MEM_LAT the respective valid pulses for one cycle and FSM returns to IDLE at next edge (one-cycle bubble between accesses).
REQ-023 f_addr[2] SHALL be captured at grant; f_rdata = mem_rdata[63:32] if captured bit=1 else mem_rdata[31:0], meaningful only when f_valid=1, else 0.
REQ-024 d_rdata = mem_rdata when d_valid=1 and access was a load; 0 otherwise (including store completion).
REQ-025 Stores SHALL complete (d_valid pulse) at T+MEM_LAT like loads.
REQ-026 f_flush=1 in the fetch grant cycle or any F_BUSY cycle SHALL set a kill flag; completion then suppresses f_valid (f_rdata=0), memory access still runs its full latency; flag clears on return to IDLE.
REQ-027 f_flush in IDLE or D_BUSY SHALL have no effect.
REQ-028 Requests arriving during BUSY SHALL be held by requester; arbiter never drops or queues them.
REQ-029 All gnt/valid/mem_en outputs SHALL be mutually exclusive per port and zero in cycles not named above.

Reset
REQ-030 rst=0 SHALL asynchronously force IDLE, latency counter 0, starve_cnt 0, kill flag 0, captured bits 0, and all outputs 0, including mid-access.
REQ-031 An access interrupted by reset SHALL produce no valid pulse after rst returns to 1.
REQ-032 First grant possible on the first rising edge with rst=1 and a request present.

Verification
REQ-033 Fetch only, MEM_LAT=2: f_req=1, f_addr=0x104, mem_rdata=0xAAAA_BBBB_1111_2222 -> f_gnt at T, f_valid at T+2, f_rdata=0xAAAABBBB, next f_gnt at T+3.
REQ-034 Simultaneous f_req and d_req(load, d_addr=0x800) -> d_gnt at T, d_valid/d_rdata=mem_rdata at T+2, f_gnt at T+3.
REQ-035 Starvation, STARVE_MAX=4: d_req and f_req held high -> 4 data grants then f_gnt, starve_cnt back to 0.
REQ-036 f_flush pulsed at T+1 of a fetch -> no f_valid at T+2, mem_en still single pulse at T, FSM IDLE at T+3.
REQ-037 rst low during D_BUSY at T+1 -> all outputs 0 immediately; after release no d_valid; pending f_req granted on first edge.
REQ-038 Store d_we=1, d_wdata=0x1234 -> mem_we=1, mem_wdata=0x1234 at T, d_valid at T+2 with d_rdata=0.
